// File: rtl/saturation_ctrl.sv
// Saturation / luma-coefficient controller.
// Software writes shadow registers at any time; a commit arms a shadow-to-active
// transfer that happens at the next frame start so the filter never sees a
// mid-frame change.
// Optional feature: define SATURATION_CTRL_RAMP_EN to ramp saturation toward its
// new value by RAMP_STEP per frame instead of jumping.
module saturation_ctrl #(
    parameter logic        VS_ACTIVE     = 1'b1,
    parameter logic [15:0] SAT_DEFAULT   = 16'h0040,
    parameter logic [15:0] YCOE0_DEFAULT = 16'h0013,
    parameter logic [15:0] YCOE1_DEFAULT = 16'h0026,
    parameter logic [15:0] YCOE2_DEFAULT = 16'h0007,
    parameter logic [15:0] RAMP_STEP     = 16'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_i,
    input  logic [1:0]  wr_addr_i,
    input  logic [15:0] wr_data_i,
    input  logic        commit_i,
    input  logic        vs_i,
    output logic [15:0] saturation_o,
    output logic [15:0] ycoe0_o,
    output logic [15:0] ycoe1_o,
    output logic [15:0] ycoe2_o,
    output logic        busy_o,
    output logic        applied_o
);

`ifdef SATURATION_CTRL_RAMP_EN
    typedef enum logic [1:0] {StIdle, StArmed, StRamp} state_e;
`else
    typedef enum logic [1:0] {StIdle, StArmed} state_e;
`endif

    state_e      state_q, state_d;
    logic        vs_q;
    logic        frame_start;
    logic [15:0] sat_sh_q, ycoe0_sh_q, ycoe1_sh_q, ycoe2_sh_q;
    logic [15:0] sat_q, sat_d;
    logic [15:0] ycoe0_q, ycoe0_d;
    logic [15:0] ycoe1_q, ycoe1_d;
    logic [15:0] ycoe2_q, ycoe2_d;

`ifdef SATURATION_CTRL_RAMP_EN
    logic [15:0] target_q, target_d;
    logic [15:0] sat_step;

    // One ramp step from cur toward tgt, clamped so it never overshoots or wraps.
    function automatic logic [15:0] step_toward(input logic [15:0] cur,
                                                input logic [15:0] tgt);
        if (tgt >= cur) begin
            return (tgt - cur <= RAMP_STEP) ? tgt : cur + RAMP_STEP;
        end else begin
            return (cur - tgt <= RAMP_STEP) ? tgt : cur - RAMP_STEP;
        end
    endfunction
`else
    logic unused_ramp_step;
    assign unused_ramp_step = ^RAMP_STEP;
`endif

    assign frame_start = (vs_i == VS_ACTIVE) && (vs_q != VS_ACTIVE);

    // Sync edge detector, shadow registers and active registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            vs_q       <= ~VS_ACTIVE;
            sat_sh_q   <= SAT_DEFAULT;
            ycoe0_sh_q <= YCOE0_DEFAULT;
            ycoe1_sh_q <= YCOE1_DEFAULT;
            ycoe2_sh_q <= YCOE2_DEFAULT;
            sat_q      <= SAT_DEFAULT;
            ycoe0_q    <= YCOE0_DEFAULT;
            ycoe1_q    <= YCOE1_DEFAULT;
            ycoe2_q    <= YCOE2_DEFAULT;
`ifdef SATURATION_CTRL_RAMP_EN
            target_q   <= SAT_DEFAULT;
`endif
        end else begin
            state_q <= state_d;
            vs_q    <= vs_i;
            sat_q   <= sat_d;
            ycoe0_q <= ycoe0_d;
            ycoe1_q <= ycoe1_d;
            ycoe2_q <= ycoe2_d;
`ifdef SATURATION_CTRL_RAMP_EN
            target_q <= target_d;
`endif
            // A write coinciding with a transfer lands after the transfer reads the shadow.
            if (wr_i) begin
                case (wr_addr_i)
                    2'd0:    sat_sh_q   <= wr_data_i;
                    2'd1:    ycoe0_sh_q <= wr_data_i;
                    2'd2:    ycoe1_sh_q <= wr_data_i;
                    default: ycoe2_sh_q <= wr_data_i;
                endcase
            end
        end
    end

`ifdef SATURATION_CTRL_RAMP_EN
    // Next ramp value: from the shadow target at transfer, else from the latched target.
    always_comb begin
        sat_step = sat_q;
        if (state_q == StArmed) begin
            sat_step = step_toward(sat_q, sat_sh_q);
        end else begin
            sat_step = step_toward(sat_q, target_q);
        end
    end
`endif

    // Commit sequencing: next state, active-register loads and the applied pulse.
    always_comb begin
        state_d   = state_q;
        sat_d     = sat_q;
        ycoe0_d   = ycoe0_q;
        ycoe1_d   = ycoe1_q;
        ycoe2_d   = ycoe2_q;
        applied_o = 1'b0;
`ifdef SATURATION_CTRL_RAMP_EN
        target_d  = target_q;
`endif
        case (state_q)
            StIdle: begin
                // A frame start here is ignored even if commit arrives with it.
                if (commit_i) state_d = StArmed;
            end
            StArmed: begin
                if (frame_start) begin
                    applied_o = 1'b1;
                    ycoe0_d   = ycoe0_sh_q;
                    ycoe1_d   = ycoe1_sh_q;
                    ycoe2_d   = ycoe2_sh_q;
`ifdef SATURATION_CTRL_RAMP_EN
                    target_d  = sat_sh_q;
                    sat_d     = sat_step;
                    state_d   = (sat_step == sat_sh_q) ? StIdle : StRamp;
`else
                    sat_d     = sat_sh_q;
                    state_d   = StIdle;
`endif
                end
            end
`ifdef SATURATION_CTRL_RAMP_EN
            StRamp: begin
                // A new commit freezes the ramp; it resumes from here after the transfer.
                if (commit_i) begin
                    state_d = StArmed;
                end else if (frame_start) begin
                    sat_d   = sat_step;
                    state_d = (sat_step == target_q) ? StIdle : StRamp;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    assign saturation_o = sat_q;
    assign ycoe0_o      = ycoe0_q;
    assign ycoe1_o      = ycoe1_q;
    assign ycoe2_o      = ycoe2_q;
    assign busy_o       = (state_q != StIdle);

endmodule
